// File: rtl/i2s_stereo_capture_pkg.sv
// Shared types and defaults for the I2S stereo capture front end.
package i2s_stereo_capture_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int SLOT_WIDTH_DEF = 32;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // Counter must hold SLOT_WIDTH+1 so an over-long slot is detectable.
  function automatic int cnt_width(input int slot_width);
    return $clog2(slot_width + 2);
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchronizer for sck/ws/sd with a registered sck rising-edge strobe.
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic ws,
  input  logic sd,
  output logic sck_rise,
  output logic ws_s,
  output logic sd_s
);

  logic [STAGES-1:0] sck_sync;
  logic [STAGES-1:0] ws_sync;
  logic [STAGES-1:0] sd_sync;
  logic              sck_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_prev <= 1'b0;
      sck_rise <= 1'b0;
      ws_s     <= 1'b0;
      sd_s     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[STAGES-2:0], sck};
      ws_sync  <= {ws_sync[STAGES-2:0], ws};
      sd_sync  <= {sd_sync[STAGES-2:0], sd};
      sck_prev <= sck_sync[STAGES-1];
      // ws/sd are registered alongside the strobe so all three stay aligned.
      sck_rise <= sck_sync[STAGES-1] & ~sck_prev;
      ws_s     <= ws_sync[STAGES-1];
      sd_s     <= sd_sync[STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_stereo_capture.sv
// I2S stereo deserializer: emits one aligned left/right pair per frame
// with a single-cycle valid strobe and a sticky framing-error flag.
module i2s_stereo_capture
  import i2s_stereo_capture_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SLOT_WIDTH  = SLOT_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  i2s_sck,
  input  logic                  i2s_ws,
  input  logic                  i2s_sd,
  output logic [DATA_WIDTH-1:0] left_data_out,
  output logic [DATA_WIDTH-1:0] right_data_out,
  output logic                  sample_valid,
  output logic                  frame_error
);

  localparam int CW = cnt_width(SLOT_WIDTH);
  localparam logic [CW-1:0] CNT_DW  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_SW  = CW'(SLOT_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_WIDTH + 1);

  logic                  bit_ev;
  logic                  ws_s;
  logic                  sd_s;
  logic                  ws_q;
  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         cnt_inc;
  logic [DATA_WIDTH-1:0] left_sr;
  logic [DATA_WIDTH-1:0] right_sr;
  logic [DATA_WIDTH-1:0] left_next;
  logic [DATA_WIDTH-1:0] right_next;
  logic [DATA_WIDTH-1:0] hold;
  logic                  boundary;
  logic                  shift_on;
  logic                  count_ok;
  logic                  hold_load;
  logic                  present;
  logic                  err;
  logic                  cnt_clr;
  logic                  cnt_step;

  i2s_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .sck     (i2s_sck),
    .ws      (i2s_ws),
    .sd      (i2s_sd),
    .sck_rise(bit_ev),
    .ws_s    (ws_s),
    .sd_s    (sd_s)
  );

  assign boundary = bit_ev & (ws_s != ws_q);
  assign shift_on = enable & bit_ev & (state != IDLE)
                  & (bit_cnt < CNT_DW);
  assign cnt_inc  = (bit_cnt == CNT_MAX) ? bit_cnt
                                         : bit_cnt + CW'(1);
  assign count_ok = (cnt_inc >= CNT_DW) && (cnt_inc <= CNT_SW);

  // The bit at a boundary still belongs to the old slot, so the
  // latched words must include this cycle's shift.
  assign left_next  = (shift_on && !ws_q)
                    ? {left_sr[DATA_WIDTH-2:0], sd_s} : left_sr;
  assign right_next = (shift_on && ws_q)
                    ? {right_sr[DATA_WIDTH-2:0], sd_s} : right_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    hold_load = 1'b0;
    present   = 1'b0;
    err       = 1'b0;
    cnt_clr   = 1'b0;
    cnt_step  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_clr = 1'b1;
    end else if (bit_ev) begin
      unique case (state)
        IDLE: begin
          if (boundary && ws_q) begin
            state_n = LEFT;
            cnt_clr = 1'b1;
          end
        end
        LEFT, RIGHT: begin
          cnt_step = 1'b1;
          if (boundary) begin
            cnt_clr = 1'b1;
            if (!count_ok) begin
              err     = 1'b1;
              state_n = IDLE;
            end else if (state == LEFT) begin
              hold_load = 1'b1;
              state_n   = RIGHT;
            end else begin
              present = 1'b1;
              state_n = LEFT;
            end
          end else if (cnt_inc > CNT_SW) begin
            err     = 1'b1;
            cnt_clr = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_q           <= 1'b0;
      bit_cnt        <= '0;
      left_sr        <= '0;
      right_sr       <= '0;
      hold           <= '0;
      left_data_out  <= '0;
      right_data_out <= '0;
      sample_valid   <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      sample_valid <= present;
      if (bit_ev) begin
        ws_q <= ws_s;
      end
      left_sr  <= left_next;
      right_sr <= right_next;
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (cnt_step) begin
        bit_cnt <= cnt_inc;
      end
      if (hold_load) begin
        hold <= left_next;
      end
      if (present) begin
        left_data_out  <= hold;
        right_data_out <= right_next;
      end
      if (err) begin
        frame_error <= 1'b1;
      end
    end
  end

endmodule
